// File: rtl/hzd_pkg.sv
// Shared constants for the hazard scoreboard: field widths, forwarding select
// encoding, mult/div operation codes and default busy latencies.
package hzd_pkg;

    localparam int unsigned TW           = 3;
    localparam int unsigned SEL_RF       = 0;
    localparam int unsigned MULT_LAT_DEF = 5;
    localparam int unsigned DIV_LAT_DEF  = 10;

    localparam logic [1:0] MD_NONE = 2'b00;
    localparam logic [1:0] MD_HILO = 2'b01;
    localparam logic [1:0] MD_MULT = 2'b10;
    localparam logic [1:0] MD_DIV  = 2'b11;

    // Both mult and div starts have the upper code bit set.
    function automatic logic md_is_start(input logic [1:0] md);
        return md[1];
    endfunction

endpackage

// File: rtl/hzd_md_timer.sv
// Multiply/divide busy countdown: loads the unit latency on a start, then
// counts down to zero; o_busy mirrors (count != 0).
module hzd_md_timer
    import hzd_pkg::*;
#(
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start_mult,
    input  logic i_start_div,
    output logic o_busy
);

    localparam int unsigned LAT_MAX = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CW      = $clog2(LAT_MAX + 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_busy;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_start_div) begin
            w_cnt_nxt = CW'(DIV_LAT);
        end else if (i_start_mult) begin
            w_cnt_nxt = CW'(MULT_LAT);
        end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - CW'(1);
        end
    end

    // Busy is registered from the next count so it equals (r_cnt != 0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_busy <= (w_cnt_nxt != '0);
        end
    end

    assign o_busy = r_busy;

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks producers in stages 1..NSTAGE after D,
// raises the D-stage stall and picks forwarding sources per consumer stage.
module hazard_scoreboard
    import hzd_pkg::*;
#(
    parameter int unsigned NSTAGE   = 3,
    parameter int unsigned TW       = hzd_pkg::TW,
    parameter int unsigned MULT_LAT = MULT_LAT_DEF,
    parameter int unsigned DIV_LAT  = DIV_LAT_DEF,
    localparam int unsigned SELW    = $clog2(NSTAGE + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   d_valid,
    input  logic [4:0]             d_rs,
    input  logic [4:0]             d_rt,
    input  logic [TW-1:0]          d_tuse_rs,
    input  logic [TW-1:0]          d_tuse_rt,
    input  logic [4:0]             d_waddr,
    input  logic [TW-1:0]          d_tnew,
    input  logic [1:0]             d_md,
    output logic                   stall,
    output logic                   md_busy,
    output logic [NSTAGE*SELW-1:0] fwd_rs,
    output logic [NSTAGE*SELW-1:0] fwd_rt
);

    logic          r_valid [1:NSTAGE];
    logic [4:0]    r_rs    [1:NSTAGE];
    logic [4:0]    r_rt    [1:NSTAGE];
    logic [4:0]    r_waddr [1:NSTAGE];
    logic [TW-1:0] r_tnew  [1:NSTAGE];
    logic [1:0]    r_md    [1:NSTAGE];

    logic [NSTAGE:1] w_wr_ok;
    logic [4:0]      w_src_rs [NSTAGE];
    logic [4:0]      w_src_rt [NSTAGE];
    logic [NSTAGE:1] w_hit_rs [NSTAGE];
    logic [NSTAGE:1] w_hit_rt [NSTAGE];

    logic [TW-1:0] w_tn_rs;
    logic [TW-1:0] w_tn_rt;
    logic          w_stall_rs;
    logic          w_stall_rt;
    logic          w_md_stall;
    logic          w_md_busy;
    logic          w_stall;

    // Entry array: on stall, entry 1 takes an all-zero bubble; older entries always advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= int'(NSTAGE); k++) begin
                r_valid[k] <= 1'b0;
                r_rs[k]    <= '0;
                r_rt[k]    <= '0;
                r_waddr[k] <= '0;
                r_tnew[k]  <= '0;
                r_md[k]    <= '0;
            end
        end else begin
            if (w_stall) begin
                r_valid[1] <= 1'b0;
                r_rs[1]    <= '0;
                r_rt[1]    <= '0;
                r_waddr[1] <= '0;
                r_tnew[1]  <= '0;
                r_md[1]    <= '0;
            end else begin
                r_valid[1] <= d_valid;
                r_rs[1]    <= d_rs;
                r_rt[1]    <= d_rt;
                r_waddr[1] <= d_waddr;
                r_tnew[1]  <= d_tnew;
                r_md[1]    <= d_md;
            end
            for (int k = 2; k <= int'(NSTAGE); k++) begin
                r_valid[k] <= r_valid[k-1];
                r_rs[k]    <= r_rs[k-1];
                r_rt[k]    <= r_rt[k-1];
                r_waddr[k] <= r_waddr[k-1];
                r_tnew[k]  <= (r_tnew[k-1] == '0) ? '0 : r_tnew[k-1] - TW'(1);
                r_md[k]    <= r_md[k-1];
            end
        end
    end

    // Match matrix: consumer j (0 = D) against every strictly older producer k.
    for (genvar k = 1; k <= NSTAGE; k++) begin : g_wr
        assign w_wr_ok[k] = r_valid[k] && (r_waddr[k] != 5'd0);
    end

    for (genvar j = 0; j < NSTAGE; j++) begin : g_cons
        if (j == 0) begin : g_d
            assign w_src_rs[j] = d_rs;
            assign w_src_rt[j] = d_rt;
        end else begin : g_pipe
            assign w_src_rs[j] = r_rs[j];
            assign w_src_rt[j] = r_rt[j];
        end
        for (genvar k = 1; k <= NSTAGE; k++) begin : g_prod
            if (k > j) begin : g_live
                assign w_hit_rs[j][k] = w_wr_ok[k] && (r_waddr[k] == w_src_rs[j]);
                assign w_hit_rt[j][k] = w_wr_ok[k] && (r_waddr[k] == w_src_rt[j]);
            end else begin : g_dead
                assign w_hit_rs[j][k] = 1'b0;
                assign w_hit_rt[j][k] = 1'b0;
            end
        end
    end

    // Forward select: scan oldest to youngest so the nearest match overrides.
    always_comb begin
        logic [SELW-1:0] w_sel_rs;
        logic [SELW-1:0] w_sel_rt;
        fwd_rs   = '0;
        fwd_rt   = '0;
        w_sel_rs = SELW'(SEL_RF);
        w_sel_rt = SELW'(SEL_RF);
        for (int j = 0; j < int'(NSTAGE); j++) begin
            w_sel_rs = SELW'(SEL_RF);
            w_sel_rt = SELW'(SEL_RF);
            for (int k = int'(NSTAGE); k >= 1; k--) begin
                if (w_hit_rs[j][k]) begin
                    w_sel_rs = (r_tnew[k] == '0) ? SELW'(k) : SELW'(SEL_RF);
                end
                if (w_hit_rt[j][k]) begin
                    w_sel_rt = (r_tnew[k] == '0) ? SELW'(k) : SELW'(SEL_RF);
                end
            end
            fwd_rs[j*SELW +: SELW] = w_sel_rs;
            fwd_rt[j*SELW +: SELW] = w_sel_rt;
        end
    end

    // Remaining latency of the nearest producer for each D operand.
    always_comb begin
        w_tn_rs = '0;
        w_tn_rt = '0;
        for (int k = int'(NSTAGE); k >= 1; k--) begin
            if (w_hit_rs[0][k]) begin
                w_tn_rs = r_tnew[k];
            end
            if (w_hit_rt[0][k]) begin
                w_tn_rt = r_tnew[k];
            end
        end
    end

    assign w_stall_rs = (d_rs != 5'd0) && (d_tuse_rs != '1) && (w_tn_rs > d_tuse_rs);
    assign w_stall_rt = (d_rt != 5'd0) && (d_tuse_rt != '1) && (w_tn_rt > d_tuse_rt);
    assign w_md_stall = (d_md != MD_NONE) &&
                        (w_md_busy || (r_valid[1] && md_is_start(r_md[1])));
    assign w_stall    = d_valid && (w_stall_rs || w_stall_rt || w_md_stall);

    hzd_md_timer #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_timer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_start_mult (d_valid && !w_stall && (d_md == MD_MULT)),
        .i_start_div  (d_valid && !w_stall && (d_md == MD_DIV)),
        .o_busy       (w_md_busy)
    );

    assign stall   = w_stall;
    assign md_busy = w_md_busy;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: load-use, youngest-producer, mult/div
// busy, reset abort and a 5-stage build, with hand-computed expectations.
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        d_valid;
    logic [4:0]  d_rs;
    logic [4:0]  d_rt;
    logic [2:0]  d_tuse_rs;
    logic [2:0]  d_tuse_rt;
    logic [4:0]  d_waddr;
    logic [2:0]  d_tnew;
    logic [1:0]  d_md;

    logic        stall;
    logic        md_busy;
    logic [5:0]  fwd_rs;
    logic [5:0]  fwd_rt;
    logic        stall5;
    logic        md_busy5;
    logic [14:0] fwd_rs5;
    logic [14:0] fwd_rt5;

    int n_run  = 0;
    int n_fail = 0;

    hazard_scoreboard u3 (
        .clk (clk), .rst_n (rst_n), .d_valid (d_valid),
        .d_rs (d_rs), .d_rt (d_rt), .d_tuse_rs (d_tuse_rs), .d_tuse_rt (d_tuse_rt),
        .d_waddr (d_waddr), .d_tnew (d_tnew), .d_md (d_md),
        .stall (stall), .md_busy (md_busy), .fwd_rs (fwd_rs), .fwd_rt (fwd_rt)
    );

    hazard_scoreboard #(.NSTAGE(5)) u5 (
        .clk (clk), .rst_n (rst_n), .d_valid (d_valid),
        .d_rs (d_rs), .d_rt (d_rt), .d_tuse_rs (d_tuse_rs), .d_tuse_rt (d_tuse_rt),
        .d_waddr (d_waddr), .d_tnew (d_tnew), .d_md (d_md),
        .stall (stall5), .md_busy (md_busy5), .fwd_rs (fwd_rs5), .fwd_rt (fwd_rt5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [2:0] trs, input logic [2:0] trt,
                         input logic [4:0] wa, input logic [2:0] tn, input logic [1:0] md);
        d_valid   = v;
        d_rs      = rs;
        d_rt      = rt;
        d_tuse_rs = trs;
        d_tuse_rt = trt;
        d_waddr   = wa;
        d_tnew    = tn;
        d_md      = md;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 3'd7, 3'd7, 5'd0, 3'd0, 2'b00);
    endtask

    initial begin
        // Reset: an mflo in D must not stall while rst_n is low.
        rst_n = 1'b0;
        drive(1'b1, 5'd1, 5'd0, 3'd0, 3'd7, 5'd0, 3'd0, 2'b01);
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_md_busy", 32'(md_busy), 32'd0);
        chk("rst_fwd_rs", 32'(fwd_rs), 32'd0);
        chk("rst_fwd_rt", 32'(fwd_rt), 32'd0);
        #9;
        idle();
        rst_n = 1'b1;
        tick();

        // Load-use: lw $1 (tnew=2) then add reading $1 with tuse=1.
        drive(1'b1, 5'd5, 5'd0, 3'd1, 3'd7, 5'd1, 3'd2, 2'b00);
        chk("lw_issue_stall", 32'(stall), 32'd0);
        tick();
        drive(1'b1, 5'd1, 5'd4, 3'd1, 3'd1, 5'd6, 3'd1, 2'b00);
        chk("lu_stall_E", 32'(stall), 32'd1);
        chk("lu_fwd_D_E", 32'(fwd_rs[1:0]), 32'd0);
        tick();
        chk("lu_stall_M", 32'(stall), 32'd0);
        chk("lu_fwd_D_M", 32'(fwd_rs[1:0]), 32'd0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 3'd7, 3'd7, 5'd2, 3'd1, 2'b00);
        chk("lu_fwd_E_from_W", 32'(fwd_rs[3:2]), 32'd3);
        chk("lu_after_stall", 32'(stall), 32'd0);
        tick();
        idle();
        tick();

        // beq $2,$6 with addu $2 in M and add $6 in W, both ready.
        drive(1'b1, 5'd2, 5'd6, 3'd0, 3'd0, 5'd0, 3'd0, 2'b00);
        chk("beq_stall", 32'(stall), 32'd0);
        chk("beq_fwd_rs", 32'(fwd_rs[1:0]), 32'd2);
        chk("beq_fwd_rt", 32'(fwd_rt[1:0]), 32'd3);
        tick();

        // Two writers of $3: the younger one governs stall and forwarding.
        drive(1'b1, 5'd0, 5'd0, 3'd7, 3'd7, 5'd3, 3'd1, 2'b00);
        tick();
        drive(1'b1, 5'd0, 5'd0, 3'd7, 3'd7, 5'd3, 3'd1, 2'b00);
        tick();
        drive(1'b1, 5'd3, 5'd0, 3'd0, 3'd7, 5'd0, 3'd0, 2'b00);
        chk("young_E_stall", 32'(stall), 32'd1);
        chk("young_E_fwd", 32'(fwd_rs[1:0]), 32'd0);
        d_tuse_rs = 3'd1;
        #1;
        chk("young_E_tuse1", 32'(stall), 32'd0);
        idle();
        tick();
        drive(1'b1, 5'd3, 5'd0, 3'd0, 3'd7, 5'd0, 3'd0, 2'b00);
        chk("young_M_stall", 32'(stall), 32'd0);
        chk("young_M_fwd", 32'(fwd_rs[1:0]), 32'd2);
        tick();

        // div then mflo: busy for DIV_LAT cycles with D frozen throughout.
        drive(1'b1, 5'd4, 5'd5, 3'd1, 3'd1, 5'd0, 3'd0, 2'b11);
        chk("div_issue_stall", 32'(stall), 32'd0);
        chk("div_issue_busy", 32'(md_busy), 32'd0);
        tick();
        drive(1'b1, 5'd0, 5'd0, 3'd7, 3'd7, 5'd8, 3'd1, 2'b01);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("div_busy_%0d", i), 32'(md_busy), 32'd1);
            chk($sformatf("div_stall_%0d", i), 32'(stall), 32'd1);
            tick();
        end
        chk("div_done_busy", 32'(md_busy), 32'd0);
        chk("div_done_stall", 32'(stall), 32'd0);
        tick();

        // mult, then mthi reading $8 (mflo in M); reset mid-count.
        drive(1'b1, 5'd0, 5'd0, 3'd7, 3'd7, 5'd0, 3'd0, 2'b10);
        chk("mult_issue_stall", 32'(stall), 32'd0);
        tick();
        drive(1'b1, 5'd8, 5'd0, 3'd0, 3'd7, 5'd0, 3'd0, 2'b01);
        chk("mult_stall", 32'(stall), 32'd1);
        chk("mult_busy", 32'(md_busy), 32'd1);
        chk("mthi_fwd", 32'(fwd_rs[1:0]), 32'd2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_busy", 32'(md_busy), 32'd0);
        chk("rstmid_stall", 32'(stall), 32'd0);
        chk("rstmid_fwd_rs", 32'(fwd_rs), 32'd0);
        chk("rstmid_fwd_rt", 32'(fwd_rt), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(md_busy), 32'd0);
        chk("post_rst_stall", 32'(stall), 32'd0);
        chk("post_rst_fwd", 32'(fwd_rs[1:0]), 32'd0);

        // Every stage writes $0 with tnew>0; a $0 reader must see nothing.
        drive(1'b1, 5'd0, 5'd0, 3'd7, 3'd7, 5'd0, 3'd2, 2'b00);
        tick();
        tick();
        tick();
        drive(1'b1, 5'd0, 5'd0, 3'd0, 3'd0, 5'd0, 3'd0, 2'b00);
        chk("zero_stall", 32'(stall), 32'd0);
        chk("zero_fwd_rs", 32'(fwd_rs), 32'd0);
        chk("zero_fwd_rt", 32'(fwd_rt), 32'd0);
        tick();

        // 5-stage build: producer of $9 (tnew=3) reaches stage 4 ready.
        idle();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        drive(1'b1, 5'd0, 5'd0, 3'd7, 3'd7, 5'd9, 3'd3, 2'b00);
        tick();
        drive(1'b1, 5'd9, 5'd0, 3'd7, 3'd7, 5'd0, 3'd0, 2'b00);
        chk("n5_unused_tuse", 32'(stall5), 32'd0);
        tick();
        idle();
        tick();
        drive(1'b1, 5'd9, 5'd0, 3'd0, 3'd7, 5'd0, 3'd0, 2'b00);
        chk("n5_stall_s3", 32'(stall5), 32'd1);
        chk("n3_stall_s3", 32'(stall), 32'd1);
        tick();
        chk("n5_stall_s4", 32'(stall5), 32'd0);
        chk("n5_fwd_rs", 32'(fwd_rs5), 32'd2052);
        chk("n5_fwd_rt", 32'(fwd_rt5), 32'd0);
        chk("n3_dropped_stall", 32'(stall), 32'd0);
        chk("n3_dropped_fwd", 32'(fwd_rs), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
